// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline defines: register/enable encodings, stall-vector bit indices,
// stall-vector constants and stall-cause encodings.
package hazard_ctrl_pkg;

  typedef logic [4:0] RegAddrBus;
  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;

  // STALL_EXE is the EX bit index; STALL_EX is taken by the EX stall vector.
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EXE = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LD   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    CAUSE_RUN     = 2'd0,
    CAUSE_LDSTALL = 2'd1,
    CAUSE_EXSTALL = 2'd2,
    CAUSE_FLUSH   = 2'd3
  } cause_e;

  function automatic logic src_hit(input logic rd, input RegAddrBus src, input RegAddrBus dst);
    return rd && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use hazard detection, stall/bubble generation, stall-cause status
// and stall-cycle counting for the five-stage pipeline.
//
// state         | meaning
// CAUSE_RUN     | previous cycle ran without stall
// CAUSE_LDSTALL | previous cycle was a load-use stall
// CAUSE_EXSTALL | previous cycle was an EX multi-cycle stall
// CAUSE_FLUSH   | previous cycle was a flush
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_reg1_read_i,
  input  logic [4:0]       id_reg1_addr_i,
  input  logic             id_reg2_read_i,
  input  logic [4:0]       id_reg2_addr_i,
  input  logic             id_wreg_i,
  input  logic [4:0]       id_wd_i,
  input  logic             id_is_load_i,
  input  logic             stallreq_ex_i,
  input  logic             flush_i,
  input  logic             cnt_clr_i,
  output logic [5:0]       stall_o,
  output logic             bubble_o,
  output logic [1:0]       cause_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic      ex_ld_v_q;
  logic      ex_ld_v_d;
  RegAddrBus ex_ld_wd_q;
  RegAddrBus ex_ld_wd_d;
  logic      ld_hazard;
  cause_e    win_cause;
  cause_e    cause_q;
  cause_e    cause_d;

  assign ld_hazard = ex_ld_v_q && (ex_ld_wd_q != 5'd0) &&
                     (src_hit(id_reg1_read_i, id_reg1_addr_i, ex_ld_wd_q) ||
                      src_hit(id_reg2_read_i, id_reg2_addr_i, ex_ld_wd_q));

  // Reset forces a quiet pipeline even though stall requests may still be up.
  always_comb begin
    stall_o   = STALL_NONE;
    bubble_o  = 1'b0;
    win_cause = CAUSE_RUN;
    if (rst == RstEnable) begin
      stall_o   = STALL_NONE;
    end else if (flush_i) begin
      win_cause = CAUSE_FLUSH;
    end else if (stallreq_ex_i) begin
      stall_o   = STALL_EX;
      win_cause = CAUSE_EXSTALL;
    end else if (ld_hazard) begin
      stall_o   = STALL_LD;
      bubble_o  = 1'b1;
      win_cause = CAUSE_LDSTALL;
    end
  end

  always_comb begin
    ex_ld_v_d  = ex_ld_v_q;
    ex_ld_wd_d = ex_ld_wd_q;
    if (flush_i) begin
      ex_ld_v_d = 1'b0;
    end else if (stall_o[STALL_EXE]) begin
      ex_ld_v_d = ex_ld_v_q;
    end else if (bubble_o) begin
      ex_ld_v_d = 1'b0;
    end else begin
      ex_ld_v_d  = id_is_load_i && (id_wreg_i == WriteEnable);
      ex_ld_wd_d = id_wd_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ld_v_q  <= 1'b0;
      ex_ld_wd_q <= 5'd0;
    end else begin
      ex_ld_v_q  <= ex_ld_v_d;
      ex_ld_wd_q <= ex_ld_wd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_q <= CAUSE_RUN;
    end else begin
      cause_q <= cause_d;
    end
  end

  always_comb begin
    cause_d = win_cause;
  end

  always_comb begin
    cause_o = cause_q;
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr_i),
    .inc_i (stall_o != STALL_NONE),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a 4-bit stall counter so saturation is reachable.
module tb_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_reg1_read_i, id_reg2_read_i, id_wreg_i, id_is_load_i;
  logic [4:0]    id_reg1_addr_i, id_reg2_addr_i, id_wd_i;
  logic          stallreq_ex_i, flush_i, cnt_clr_i;
  logic [5:0]    stall_o;
  logic          bubble_o;
  logic [1:0]    cause_o;
  logic [CW-1:0] stall_cnt_o;

  int total  = 0;
  int passed = 0;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .id_wreg_i      (id_wreg_i),
    .id_wd_i        (id_wd_i),
    .id_is_load_i   (id_is_load_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .flush_i        (flush_i),
    .cnt_clr_i      (cnt_clr_i),
    .stall_o        (stall_o),
    .bubble_o       (bubble_o),
    .cause_o        (cause_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one ID-stage instruction and let combinational outputs settle.
  task automatic id_set(input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                        input logic wr, input logic [4:0] wd, input logic ld);
    id_reg1_read_i = r1; id_reg1_addr_i = a1;
    id_reg2_read_i = r2; id_reg2_addr_i = a2;
    id_wreg_i = wr; id_wd_i = wd; id_is_load_i = ld;
    #1;
  endtask

  initial begin
    rst = 1'b1; stallreq_ex_i = 1'b0; flush_i = 1'b0; cnt_clr_i = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_stall", stall_o, 0);
    chk("rst_bubble", bubble_o, 0);
    chk("rst_cause", cause_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    stallreq_ex_i = 1'b1; #1;
    chk("rst_forces_stall0", stall_o, 0);
    stallreq_ex_i = 1'b0;
    tick(); #3; rst = 1'b0;

    // load-use via reg1
    tick();
    id_set(0, 0, 0, 0, 1, 3, 1);
    tick();
    id_set(1, 3, 0, 0, 1, 7, 0);
    chk("lu_stall", stall_o, 6'b000111);
    chk("lu_bubble", bubble_o, 1);
    tick();
    chk("lu_after_stall", stall_o, 0);
    chk("lu_after_bubble", bubble_o, 0);
    chk("lu_cause", cause_o, 1);
    chk("lu_cnt", stall_cnt_o, 1);
    tick();
    chk("lu_cause_run", cause_o, 0);

    // register 0 never hazards; mismatched address does not hazard
    id_set(0, 0, 0, 0, 1, 0, 1);
    tick();
    id_set(1, 0, 1, 0, 0, 0, 0);
    chk("zero_reg", stall_o, 0);
    id_set(0, 0, 0, 0, 1, 4, 1);
    tick();
    id_set(0, 4, 1, 5, 0, 0, 0);
    chk("diff_reg", stall_o, 0);
    // load-use via reg2
    id_set(0, 0, 0, 0, 1, 9, 1);
    tick();
    id_set(0, 0, 1, 9, 0, 0, 0);
    chk("lu_reg2", stall_o, 6'b000111);
    tick();
    chk("lu_reg2_cnt", stall_cnt_o, 2);
    id_set(0, 0, 0, 0, 0, 0, 0);
    tick();

    // EX stall overlapping a load-use hazard
    id_set(0, 0, 0, 0, 1, 6, 1);
    tick();
    stallreq_ex_i = 1'b1;
    id_set(1, 6, 0, 0, 1, 8, 0);
    chk("ov_stall1", stall_o, 6'b001111);
    chk("ov_bubble1", bubble_o, 0);
    tick();
    chk("ov_stall2", stall_o, 6'b001111);
    chk("ov_cause_ex", cause_o, 2);
    tick();
    chk("ov_stall3", stall_o, 6'b001111);
    tick();
    stallreq_ex_i = 1'b0; #1;
    chk("ov_ld_stall", stall_o, 6'b000111);
    chk("ov_ld_bubble", bubble_o, 1);
    tick();
    chk("ov_done", stall_o, 0);
    chk("ov_cause_ld", cause_o, 1);
    chk("ov_cnt", stall_cnt_o, 6);

    // flush in a hazard cycle
    id_set(0, 0, 0, 0, 1, 10, 1);
    tick();
    flush_i = 1'b1;
    id_set(1, 10, 0, 0, 0, 0, 0);
    chk("fl_stall", stall_o, 0);
    chk("fl_bubble", bubble_o, 0);
    tick();
    flush_i = 1'b0; #1;
    chk("fl_cleared", stall_o, 0);
    chk("fl_cause", cause_o, 3);
    chk("fl_cnt", stall_cnt_o, 6);
    flush_i = 1'b1; stallreq_ex_i = 1'b1; #1;
    chk("fl_over_ex", stall_o, 0);
    flush_i = 1'b0; stallreq_ex_i = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0);

    // reset in the middle of an EX stall with counter at 5
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0; #1;
    chk("clr_cnt", stall_cnt_o, 0);
    stallreq_ex_i = 1'b1;
    repeat (5) tick();
    chk("pre_rst_cnt", stall_cnt_o, 5);
    #2; rst = 1'b1; #1;
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_cnt", stall_cnt_o, 0);
    chk("mid_rst_cause", cause_o, 0);
    stallreq_ex_i = 1'b0;
    tick(); #2; rst = 1'b0;
    tick();
    chk("post_rst_cause", cause_o, 0);
    chk("post_rst_cnt", stall_cnt_o, 0);

    // saturation, then clear beats increment
    stallreq_ex_i = 1'b1;
    repeat (20) tick();
    chk("sat_cnt", stall_cnt_o, 15);
    cnt_clr_i = 1'b1;
    tick();
    chk("clr_wins", stall_cnt_o, 0);
    cnt_clr_i = 1'b0;
    tick();
    chk("cnt_after_clr", stall_cnt_o, 1);
    stallreq_ex_i = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
